// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters plus registered,
// blank-masked RGB, sync pins, an active flag and a once-per-frame blanking tick.
module vga_timing_gen #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h_counter,
  output logic [9:0] v_counter,
  input  logic [2:0] color_r_in,
  input  logic [2:0] color_g_in,
  input  logic [2:0] color_b_in,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [2:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       active,
  output logic       frame_tick
);

  localparam int H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START   = H_VISIBLE + H_FRONT;
  localparam int HS_END     = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int VS_START   = V_VISIBLE + V_FRONT;
  localparam int VS_END     = V_VISIBLE + V_FRONT + V_SYNC;
  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
  end

  logic [9:0] hCount_q, hCount_d;
  logic [9:0] vCount_q, vCount_d;
  logic [2:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       active_q, active_d, tick_q, tick_d;
  logic       hWrap, vWrap, visible, hsyncOn, vsyncOn;
  int         hPos, vPos;

  always_comb begin
    hPos     = int'(hCount_q);
    vPos     = int'(vCount_q);
    hWrap    = (hCount_q == H_MAX);
    vWrap    = (vCount_q == V_MAX);
    hCount_d = hWrap ? 10'd0 : hCount_q + 10'd1;
    vCount_d = vCount_q;
    if (hWrap) begin
      vCount_d = vWrap ? 10'd0 : vCount_q + 10'd1;
    end
  end

  // Outputs describe the pixel at the current counters and land one edge later,
  // so colour, sync and active stay mutually aligned at the connector.
  always_comb begin
    visible  = (hPos < H_VISIBLE) && (vPos < V_VISIBLE);
    hsyncOn  = (hPos >= HS_START) && (hPos < HS_END);
    vsyncOn  = (vPos >= VS_START) && (vPos < VS_END);
    red_d    = visible ? color_r_in : 3'd0;
    green_d  = visible ? color_g_in : 3'd0;
    blue_d   = visible ? color_b_in : 3'd0;
    hsync_d  = hsyncOn ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d  = vsyncOn ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    active_d = visible;
    tick_d   = hWrap && (vPos == V_VISIBLE - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hCount_q <= 10'd0;
      vCount_q <= 10'd0;
      red_q    <= 3'd0;
      green_q  <= 3'd0;
      blue_q   <= 3'd0;
      hsync_q  <= ~SYNC_ACTIVE;
      vsync_q  <= ~SYNC_ACTIVE;
      active_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      hCount_q <= hCount_d;
      vCount_q <= vCount_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      tick_q   <= tick_d;
    end
  end

  assign h_counter  = hCount_q;
  assign v_counter  = vCount_q;
  assign vga_r      = red_q;
  assign vga_g      = green_q;
  assign vga_b      = blue_q;
  assign vga_hsync  = hsync_q;
  assign vga_vsync  = vsync_q;
  assign active     = active_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster; expected outputs come from a
// pixel-index model (cycle count -> column/line) with random renderer colours.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] colorR = 3'd0, colorG = 3'd0, colorB = 3'd0;
  logic [9:0] hCounter, vCounter;
  logic [2:0] vgaR, vgaG, vgaB;
  logic       vgaHsync, vgaVsync, activeOut, frameTick;

  int errors = 0;
  int checks = 0;
  int k = 0;
  int tickCount, activeCount, hsLowCount, vsLowCount;
  int tickAt[$];
  logic [2:0] sentR, sentG, sentB;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .h_counter(hCounter), .v_counter(vCounter),
    .color_r_in(colorR), .color_g_in(colorG), .color_b_in(colorB),
    .vga_r(vgaR), .vga_g(vgaG), .vga_b(vgaB),
    .vga_hsync(vgaHsync), .vga_vsync(vgaVsync),
    .active(activeOut), .frame_tick(frameTick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic clearStats();
    tickCount = 0; activeCount = 0; hsLowCount = 0; vsLowCount = 0;
    tickAt.delete();
  endtask

  task automatic checkReset(input string tag);
    check({tag, ".h"}, 32'(hCounter), 0);
    check({tag, ".v"}, 32'(vCounter), 0);
    check({tag, ".rgb"}, 32'({vgaR, vgaG, vgaB}), 0);
    check({tag, ".hsync"}, 32'(vgaHsync), 1);
    check({tag, ".vsync"}, 32'(vgaVsync), 1);
    check({tag, ".active"}, 32'(activeOut), 0);
    check({tag, ".tick"}, 32'(frameTick), 0);
  endtask

  // k edges since reset release: counters show pixel k, registered outputs pixel k-1
  task automatic checkOutput();
    int q, h, v, expH, expV;
    bit vis;
    expH = k % HT;
    expV = (k / HT) % VT;
    check("h_counter", 32'(hCounter), expH);
    check("v_counter", 32'(vCounter), expV);
    q = k - 1;
    h = q % HT;
    v = (q / HT) % VT;
    vis = (h < HV) && (v < VV);
    check("vga_r", 32'(vgaR), vis ? 32'(sentR) : 0);
    check("vga_g", 32'(vgaG), vis ? 32'(sentG) : 0);
    check("vga_b", 32'(vgaB), vis ? 32'(sentB) : 0);
    check("active", 32'(activeOut), vis ? 1 : 0);
    check("hsync", 32'(vgaHsync), (h >= HV + HF && h < HV + HF + HS) ? 0 : 1);
    check("vsync", 32'(vgaVsync), (v >= VV + VF && v < VV + VF + VS) ? 0 : 1);
    check("frame_tick", 32'(frameTick), (h == HT - 1 && v == VV - 1) ? 1 : 0);
    if (frameTick === 1'b1) begin
      tickCount++;
      tickAt.push_back(k);
    end
    if (activeOut === 1'b1) activeCount++;
    if (vgaHsync === 1'b0) hsLowCount++;
    if (vgaVsync === 1'b0) vsLowCount++;
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      sentR = 3'($urandom);
      sentG = 3'($urandom);
      sentB = 3'($urandom);
      colorR = sentR;
      colorG = sentG;
      colorB = sentB;
      @(posedge clk);
      #1;
      k++;
      checkOutput();
    end
  endtask

  initial begin
    // Power-on reset held for five cycles
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      colorR = 3'($urandom); colorG = 3'($urandom); colorB = 3'($urandom);
      @(posedge clk);
      #1;
      checkReset("por");
    end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    #1;
    checkReset("released");

    // Three full frames of random colour
    clearStats();
    applyStimulus(3 * FRAME);
    check("tick_count", 32'(tickCount), 3);
    if (tickAt.size() == 3) begin
      check("tick_first", 32'(tickAt[0]), VV * HT);
      check("tick_gap1", 32'(tickAt[1] - tickAt[0]), FRAME);
      check("tick_gap2", 32'(tickAt[2] - tickAt[1]), FRAME);
    end
    check("active_cycles", 32'(activeCount), 3 * HV * VV);
    check("hsync_low_cycles", 32'(hsLowCount), 3 * VT * HS);
    check("vsync_low_cycles", 32'(vsLowCount), 3 * VS * HT);

    // Asynchronous reset between edges partway through a frame
    applyStimulus(5 * HT + 7);
    #3;
    rst_n = 1'b0;
    #1;
    checkReset("midreset");
    repeat (2) begin
      @(posedge clk);
      #1;
      checkReset("midhold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    clearStats();
    applyStimulus(FRAME);
    check("restart_tick_count", 32'(tickCount), 1);
    if (tickAt.size() == 1) begin
      check("restart_tick_at", 32'(tickAt[0]), VV * HT);
    end
    check("restart_active_cycles", 32'(activeCount), HV * VV);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480 @ 60 Hz VGA raster that drives every sprite renderer in the game. Produces the free-running `h_counter`/`v_counter` pixel coordinates that renderers consume. Samples the renderers' combined 3-bit-per-channel colour on the same cycle and drives registered, blank-masked RGB and sync pins to the VGA connector. It also emits a once-per-frame tick at the start of vertical blanking, so game logic (frog, cars, logs) updates positions only while nothing is being drawn.

## Interface
- `H_VISIBLE`, default 640: visible pixels per line
- `H_FRONT`, default 16: horizontal front porch (pixels)
- `H_SYNC`, default 96: hsync pulse width (pixels)
- `H_BACK`, default 48: horizontal back porch (pixels)
- `V_VISIBLE`, default 480: visible lines per frame
- `V_FRONT`, default 10: vertical front porch (lines)
- `V_SYNC`, default 2: vsync pulse width (lines)
- `V_BACK`, default 33: vertical back porch (lines)
- `SYNC_ACTIVE`, default 0: level of hsync/vsync when asserted (0 = negative polarity)

Ports (direction, width, meaning):
- `clk`, in, 1: 25 MHz pixel clock, one pixel per cycle
- `rst_n`, in, 1: asynchronous, active-low reset
- `h_counter`, out, 10: current pixel column, 0..H_TOTAL-1
- `v_counter`, out, 10: current line, 0..V_TOTAL-1
- `color_r_in`, in, 3: renderer red for the pixel at the current counters
- `color_g_in`, in, 3: renderer green for the pixel at the current counters
- `color_b_in`, in, 3: renderer blue for the pixel at the current counters
- `vga_r`, out, 3: registered red to the connector
- `vga_g`, out, 3: registered green to the connector
- `vga_b`, out, 3: registered blue to the connector
- `vga_hsync`, out, 1: registered horizontal sync
- `vga_vsync`, out, 1: registered vertical sync
- `active`, out, 1: registered; high when the `vga_*` outputs carry a visible pixel
- `frame_tick`, out, 1: one-cycle pulse at the start of vertical blanking

## Operation
- **Totals:** H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525). Both must be ≤ 1024; this is checked at elaboration.
- **Horizontal counter:** `h_counter` increments every clk. At H_TOTAL-1 it wraps to 0.
- **Vertical counter:** `v_counter` increments only on the cycle `h_counter` wraps. When both counters are at their maximum (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- **Counter arithmetic:** unsigned 10-bit; no other wrap point exists.
- **Visible region:** visible = (h_counter < H_VISIBLE) && (v_counter < V_VISIBLE).
- **Sync windows:**
  - hsync is asserted (= SYNC_ACTIVE) while h_counter ∈ [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. [656,752).
  - vsync is asserted while v_counter ∈ [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), i.e. [490,492), for the full line width.
- **RGB masking:** if visible, the `vga_*` colour outputs register `color_*_in`; otherwise they register 0. No colour is ever driven during blanking.
- **frame_tick:** high for exactly one cycle. It is registered from the cycle where h_counter = H_TOTAL-1 and v_counter = V_VISIBLE-1 (the last visible pixel of the frame). Exactly one pulse per V_TOTAL*H_TOTAL cycles.
- **Renderer contract:** renderers are combinational from the counters. The colour inputs are sampled on the same edge that advances the counters.

## Timing
- **Reset values** (async, immediate on `rst_n` low):
  - `h_counter` = 0, `v_counter` = 0
  - `vga_r/g/b` = 0, `active` = 0, `frame_tick` = 0
  - `vga_hsync` = `vga_vsync` = ~SYNC_ACTIVE (deasserted)
- **Leaving reset:** counters hold at 0 while `rst_n` is low. The first rising edge with `rst_n` high registers the outputs for pixel (0,0) and advances `h_counter` to 1.
- **Latency:** 1 cycle from counters/colour inputs to all `vga_*`, `active` and `frame_tick`. Sync and RGB are aligned to each other; no skew between them is permitted.
- **Simultaneous events:** at (H_TOTAL-1, V_TOTAL-1), both counters wrap on the same edge.
- **Reset mid-frame:** outputs clear asynchronously and the raster restarts at (0,0). No partial frame_tick is emitted.
- **No handshake:** colour inputs must be valid every cycle; undefined colour outside the visible region is harmless because it is masked.

## Test plan
- **Reset:** hold `rst_n`=0 for 5 cycles, then release → counters 0, `vga_hsync`=`vga_vsync`=1, RGB 0. After release, `h_counter` is 1 at the first edge.
- **Horizontal cadence:** run one line → `h_counter` 799→0 wrap with `v_counter` 0→1 on the same edge. `vga_hsync`=0 for exactly 96 cycles, starting on the cycle after `h_counter`=656.
- **Vertical cadence:** run one full frame (420000 cycles) → `vga_vsync`=0 for exactly 1600 cycles (lines 490–491, output delayed 1 cycle). Counters return to (0,0) after 525 lines.
- **Blanking mask:** drive `color_*_in`=3'b111 constantly → `vga_g`=7 only while `active`=1. `vga_g`=0 at the output cycles for h=640 and v=480. Exactly 307200 active cycles per frame.
- **frame_tick:** run 3 frames → exactly 3 pulses, each one cycle wide, spaced 420000 cycles apart. The first pulse fires on the cycle after (799,479).
- **Mid-frame reset:** assert `rst_n`=0 asynchronously at (300,200) between clock edges → all outputs reach their reset values before the next edge. After release, the raster restarts from (0,0) and no extra frame_tick appears.
